ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/cpu_pkg.sv | 15 +
 rtl/ifetch_unit_if.sv | 25 ++
 rtl/ifetch_unit_fifo.sv | 55 +++++
 rtl/ifetch_unit.sv | 72 +++++++
 tb/tb_ifetch_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bus widths, default reset vector and the
// fetch FSM state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned INST_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-fetch bus bundle: ROM read port on one side, decode handshake
// on the other. The fetch unit is the master of both.
interface ifetch_unit_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_read;
    logic              rom_en;
    logic [INST_W-1:0] rom_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output rom_addr, rom_read, rom_en, inst_valid, inst_data, inst_pc,
        input  rom_data, inst_ready
    );

    modport slave (
        input  rom_addr, rom_read, rom_en, inst_valid, inst_data, inst_pc,
        output rom_data, inst_ready
    );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// Instruction buffer: synchronous write, combinational head read, flush
// that empties the buffer in one edge, and full/empty flags.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Flush overrides any push/pop in the same cycle; pointers wrap naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: walks pc through the ROM into a small buffer that
// decode drains; redirects flush the buffer and reload pc.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    ifetch_unit_if.master     bus
);
    localparam int unsigned ENTRY_W = INST_W + ADDR_W;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              fetch;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ENTRY_W-1:0] head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Fetch is gated by the registered state, so the first fetch after reset
    // lands no earlier than the second rising edge.
    always_comb begin
        state_nxt = IDLE;
        fetch     = 1'b0;
        if (fetch_en) state_nxt = FETCH;
        if (state == FETCH && !redirect_valid && (!full || pop)) fetch = 1'b1;
    end

    assign pop = !empty && bus.inst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc;
        else if (fetch)          pc <= pc + 1'b1;
    end

    assign bus.rom_addr   = pc;
    assign bus.rom_en     = fetch;
    assign bus.rom_read   = fetch;
    assign bus.inst_valid = !empty;
    assign bus.inst_data  = head[ENTRY_W-1:ADDR_W];
    assign bus.inst_pc    = head[ADDR_W-1:0];

    // rom_data only reaches the buffer on fetch cycles, when the ROM is enabled.
    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (fetch),
        .wdata ({bus.rom_data, pc}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: ROM model returns data = address; checks
// reset, streaming, back-pressure, redirects, pc wrap and async reset.
module tb_ifetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    int          passed = 0;
    int          total = 0;

    ifetch_unit_if bus();

    ifetch_unit #(
        .RESET_PC   (16'h0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (bus.rom_en) bus.rom_data = {16'h0000, bus.rom_addr};
        else            bus.rom_data = 'z;
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] data, input logic [15:0] pcv);
        chk({tag, "_valid"}, 48'(bus.inst_valid), 48'd1);
        chk({tag, "_data"},  48'(bus.inst_data),  48'(data));
        chk({tag, "_pc"},    48'(bus.inst_pc),    48'(pcv));
    endtask

    initial begin
        bus.inst_ready = 1'b0;
        #12;
        chk("rst_valid", 48'(bus.inst_valid), 48'd0);
        chk("rst_rom_en", 48'(bus.rom_en), 48'd0);
        chk("rst_rom_read", 48'(bus.rom_read), 48'd0);
        chk("rst_rom_addr", 48'(bus.rom_addr), 48'h0000);

        // Scenario 1: stream with decode always ready
        step();
        rst_n = 1'b1;
        fetch_en = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        chk("s1_idle_rom_en", 48'(bus.rom_en), 48'd0);
        step(); #1;
        chk("s1_first_rom_en", 48'(bus.rom_en), 48'd1);
        chk("s1_first_rom_read", 48'(bus.rom_read), 48'd1);
        chk("s1_first_valid", 48'(bus.inst_valid), 48'd0);
        step(); #1;
        chk_head("s1_i0", 32'h0, 16'h0);
        step(); #1;
        chk_head("s1_i1", 32'h1, 16'h1);
        step(); #1;
        chk_head("s1_i2", 32'h2, 16'h2);

        // Scenario 2 + 6: back-pressure fills buffer, then steady full stream
        redirect_valid = 1'b1;
        redirect_pc = 16'h0000;
        bus.inst_ready = 1'b0;
        #1;
        chk("s2_redir_rom_en", 48'(bus.rom_en), 48'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("s2_empty", 48'(bus.inst_valid), 48'd0);
        step();
        step(); #1;
        chk("s2_full_rom_en", 48'(bus.rom_en), 48'd0);
        chk("s2_full_pc", 48'(bus.rom_addr), 48'h0002);
        chk("s2_full_count", 48'(dut.u_fifo.count), 48'd2);
        chk_head("s2_i0", 32'h0, 16'h0);
        bus.inst_ready = 1'b1;
        #1;
        chk("s6_pop_fetch", 48'(bus.rom_en), 48'd1);
        step(); #1;
        chk_head("s2_i1", 32'h1, 16'h1);
        chk("s6_count_a", 48'(dut.u_fifo.count), 48'd2);
        chk("s6_rom_en_a", 48'(bus.rom_en), 48'd1);
        step(); #1;
        chk_head("s2_i2", 32'h2, 16'h2);
        chk("s6_count_b", 48'(dut.u_fifo.count), 48'd2);
        step(); #1;
        chk_head("s2_i3", 32'h3, 16'h3);
        chk("s6_count_c", 48'(dut.u_fifo.count), 48'd2);

        // Scenario 3: redirect flushes buffered 5, 6
        redirect_valid = 1'b1;
        redirect_pc = 16'h0005;
        bus.inst_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        step();
        step(); #1;
        chk_head("s3_i5", 32'h5, 16'h5);
        chk("s3_count", 48'(dut.u_fifo.count), 48'd2);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        bus.inst_ready = 1'b1;
        #1;
        chk("s3_redir_rom_en", 48'(bus.rom_en), 48'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("s3_flushed", 48'(bus.inst_valid), 48'd0);
        chk("s3_pc", 48'(bus.rom_addr), 48'h0100);
        step(); #1;
        chk_head("s3_i100", 32'h0000_0100, 16'h0100);

        // Scenario 4: pc wraps modulo 2^16
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        step(); #1;
        chk_head("s4_iffff", 32'h0000_FFFF, 16'hFFFF);
        step(); #1;
        chk_head("s4_i0000", 32'h0, 16'h0000);
        step(); #1;
        chk_head("s4_i0001", 32'h1, 16'h0001);

        // Scenario 5: asynchronous reset mid-stream
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        bus.inst_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        step();
        step(); #1;
        chk("s5_count", 48'(dut.u_fifo.count), 48'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 48'(bus.inst_valid), 48'd0);
        chk("s5_rst_rom_en", 48'(bus.rom_en), 48'd0);
        chk("s5_rst_rom_addr", 48'(bus.rom_addr), 48'h0000);
        chk("s5_rst_count", 48'(dut.u_fifo.count), 48'd0);
        step();
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        chk("s5_idle_rom_en", 48'(bus.rom_en), 48'd0);
        step(); #1;
        chk("s5_first_rom_en", 48'(bus.rom_en), 48'd1);
        chk("s5_first_addr", 48'(bus.rom_addr), 48'h0000);
        chk("s5_first_valid", 48'(bus.inst_valid), 48'd0);
        step(); #1;
        chk_head("s5_i0", 32'h0, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
